// File: rtl/cle_engine_if.sv
// Memory-side bus of the labeling engine: image ROM read port, label SRAM port, done flag.
interface cle_engine_if;
  logic [6:0] rom_a;
  logic [7:0] rom_q;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic [7:0] sram_q;
  logic       finish;

  modport master (output rom_a, sram_a, sram_d, sram_wen, finish,
                  input  rom_q, sram_q);
  modport slave  (input  rom_a, sram_a, sram_d, sram_wen, finish,
                  output rom_q, sram_q);
endinterface

// File: rtl/cle_engine.sv
// Two-pass 8-connected component labeling of a 32x32 binary image.
// The equivalence table is kept flat (every label points straight at its root).
module cle_engine (
  input  logic         clk,
  input  logic         reset,
  cle_engine_if.master bus
);
  typedef enum logic [2:0] {LOAD, PASS1, P2_RD, P2_WAIT, P2_WB, P2_LAST, DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         ld_cnt_q, ld_cnt_d;
  logic [1023:0]      img_q, img_d;
  logic [9:0]         pix_q, pix_d;
  logic [31:0][7:0]   lb_q, lb_d;
  logic [7:0]         nw_q, nw_d;
  logic [255:0][7:0]  par_q, par_d;
  logic [7:0]         nxt_q, nxt_d;
  logic [9:0]         sa_q, sa_d;
  logic [7:0]         sd_q, sd_d;
  logic               wen_q, wen_d;

  logic [4:0]         row, col;
  logic               fg, has_nb;
  logic [3:0][7:0]    nb_lbl, nb_root;
  logic [7:0]         min_root, pix_lbl;
  logic [6:0]         ld_idx;

  assign row    = pix_q[9:5];
  assign col    = pix_q[4:0];
  assign fg     = img_q[pix_q];
  // rom_q currently carries the byte addressed one cycle earlier
  assign ld_idx = ld_cnt_q[6:0] - 7'd1;

  // Line buffer: entries left of col hold the current row, the rest the previous row.
  always_comb begin
    nb_lbl[0] = (col != 5'd0) ? lb_q[col - 5'd1] : 8'd0;
    nb_lbl[1] = (row != 5'd0 && col != 5'd0) ? nw_q : 8'd0;
    nb_lbl[2] = (row != 5'd0) ? lb_q[col] : 8'd0;
    nb_lbl[3] = (row != 5'd0 && col != 5'd31) ? lb_q[col + 5'd1] : 8'd0;
    has_nb    = 1'b0;
    min_root  = 8'd0;
    for (int k = 0; k < 4; k++) begin
      nb_root[k] = par_q[nb_lbl[k]];
      if (nb_root[k] != 8'd0 && (!has_nb || nb_root[k] < min_root)) min_root = nb_root[k];
      if (nb_root[k] != 8'd0) has_nb = 1'b1;
    end
    pix_lbl = !fg ? 8'd0 : (has_nb ? min_root : nxt_q);
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    img_d    = img_q;
    pix_d    = pix_q;
    lb_d     = lb_q;
    nw_d     = nw_q;
    par_d    = par_q;
    nxt_d    = nxt_q;
    sa_d     = sa_q;
    sd_d     = sd_q;
    wen_d    = 1'b1;
    case (state_q)
      LOAD: begin
        ld_cnt_d = ld_cnt_q + 8'd1;
        if (ld_cnt_q != 8'd0) begin
          for (int j = 0; j < 8; j++) img_d[{ld_idx, 3'(j)}] = bus.rom_q[7-j];
          if (ld_cnt_q == 8'd128) begin
            ld_cnt_d = ld_cnt_q;
            state_d  = PASS1;
          end
        end
      end
      PASS1: begin
        sa_d      = pix_q;
        sd_d      = pix_lbl;
        wen_d     = 1'b0;
        lb_d[col] = pix_lbl;
        nw_d      = lb_q[col];
        if (fg && !has_nb) begin
          par_d[nxt_q] = nxt_q;
          nxt_d        = nxt_q + 8'd1;
        end else if (fg) begin
          // merge every neighbour root into the smallest one, keeping the table flat
          for (int i = 1; i < 256; i++)
            for (int k = 0; k < 4; k++)
              if (nb_root[k] != 8'd0 && par_q[i] == nb_root[k]) par_d[i] = min_root;
        end
        pix_d = pix_q + 10'd1;
        if (pix_q == 10'd1023) state_d = P2_RD;
      end
      P2_RD: begin
        sa_d    = pix_q;
        state_d = P2_WAIT;
      end
      P2_WAIT: state_d = P2_WB;
      P2_WB: begin
        sa_d    = pix_q;
        sd_d    = par_q[bus.sram_q];
        wen_d   = 1'b0;
        pix_d   = pix_q + 10'd1;
        state_d = (pix_q == 10'd1023) ? P2_LAST : P2_RD;
      end
      P2_LAST: state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      ld_cnt_q <= 8'd0;
      img_q    <= '0;
      pix_q    <= 10'd0;
      lb_q     <= '0;
      nw_q     <= 8'd0;
      par_q    <= '0;
      nxt_q    <= 8'd1;
      sa_q     <= 10'd0;
      sd_q     <= 8'd0;
      wen_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      img_q    <= img_d;
      pix_q    <= pix_d;
      lb_q     <= lb_d;
      nw_q     <= nw_d;
      par_q    <= par_d;
      nxt_q    <= nxt_d;
      sa_q     <= sa_d;
      sd_q     <= sd_d;
      wen_q    <= wen_d;
    end
  end

  assign bus.rom_a    = ld_cnt_q[6:0];
  assign bus.sram_a   = sa_q;
  assign bus.sram_d   = sd_q;
  assign bus.sram_wen = wen_q;
  assign bus.finish   = (state_q == DONE);
endmodule

// File: tb/tb_cle_engine.sv
// Bench for cle_engine: ROM/SRAM models, flood-fill reference labeling, label-equivalence checks.
module tb_cle_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cle_engine_if bus ();
  cle_engine dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rom [128];
  logic [7:0] mem [1024];
  int wr_cnt, wr_after_fin;

  always @(posedge clk) begin
    bus.rom_q <= rom[bus.rom_a];
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'hEE;
      wr_cnt       <= 0;
      wr_after_fin <= 0;
    end else if (!bus.sram_wen) begin
      mem[bus.sram_a] <= bus.sram_d;
      wr_cnt          <= wr_cnt + 1;
      if (bus.finish) wr_after_fin <= wr_after_fin + 1;
    end else begin
      bus.sram_q <= mem[bus.sram_a];
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // reference model
  bit img [32][32];
  int comp [32][32];
  int ncomp;

  task automatic clr_img();
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) img[r][c] = 1'b0;
  endtask

  task automatic flood();
    int q[$];
    ncomp = 0;
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) comp[r][c] = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (img[r][c] && comp[r][c] == 0) begin
          ncomp++;
          comp[r][c] = ncomp;
          q.push_back(r*32 + c);
          while (q.size() > 0) begin
            int p, pr, pc;
            p  = q.pop_front();
            pr = p / 32;
            pc = p % 32;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                int nr, nc;
                nr = pr + dr;
                nc = pc + dc;
                if (nr >= 0 && nr < 32 && nc >= 0 && nc < 32)
                  if (img[nr][nc] && comp[nr][nc] == 0) begin
                    comp[nr][nc] = ncomp;
                    q.push_back(nr*32 + nc);
                  end
              end
          end
        end
  endtask

  // pixels with no earlier-scanned foreground neighbour each consume a provisional label
  function automatic int prov_cnt();
    int n = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (img[r][c]) begin
          bit nb;
          nb = 0;
          if (c > 0 && img[r][c-1]) nb = 1;
          if (r > 0 && c > 0 && img[r-1][c-1]) nb = 1;
          if (r > 0 && img[r-1][c]) nb = 1;
          if (r > 0 && c < 31 && img[r-1][c+1]) nb = 1;
          if (!nb) n++;
        end
    return n;
  endfunction

  task automatic load_rom();
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 8; j++) rom[k][7-j] = img[k/4][8*(k%4) + j];
  endtask

  task automatic do_reset(input string tn);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk({tn, ":rst_rom_a"}, int'(bus.rom_a), 0);
    chk({tn, ":rst_sram_a"}, int'(bus.sram_a), 0);
    chk({tn, ":rst_sram_d"}, int'(bus.sram_d), 0);
    chk({tn, ":rst_wen"}, int'(bus.sram_wen), 1);
    chk({tn, ":rst_finish"}, int'(bus.finish), 0);
    reset = 1'b0;
  endtask

  task automatic wait_fin(input string tn);
    int cyc = 0;
    while (!bus.finish && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tn, ":finish"}, int'(bus.finish), 1);
    repeat (10) @(negedge clk);
    chk({tn, ":finish_hold"}, int'(bus.finish), 1);
  endtask

  task automatic verify(input string tn, input int exp_n);
    int e_bg = 0, e_fg = 0, e_same = 0, e_dist = 0, nlab = 0;
    int c2l [1025];
    int l2c [256];
    for (int i = 0; i < 1025; i++) c2l[i] = -1;
    for (int i = 0; i < 256; i++) l2c[i] = -1;
    for (int p = 0; p < 1024; p++) begin
      int r, c, l, k;
      r = p / 32;
      c = p % 32;
      l = int'(mem[p]);
      if (!img[r][c]) begin
        if (l != 0) e_bg++;
      end else if (l == 0) begin
        e_fg++;
      end else begin
        k = comp[r][c];
        if (c2l[k] < 0) c2l[k] = l;
        else if (c2l[k] != l) e_same++;
        if (l2c[l] < 0) begin
          l2c[l] = k;
          nlab++;
        end else if (l2c[l] != k) e_dist++;
      end
    end
    chk({tn, ":bg_zero"}, e_bg, 0);
    chk({tn, ":fg_nonzero"}, e_fg, 0);
    chk({tn, ":same_obj"}, e_same, 0);
    chk({tn, ":distinct"}, e_dist, 0);
    chk({tn, ":nlabels"}, nlab, ncomp);
    if (exp_n >= 0) chk({tn, ":nobj"}, nlab, exp_n);
    chk({tn, ":wr_after_fin"}, wr_after_fin, 0);
    chk({tn, ":wr_cnt_ok"}, int'(wr_cnt >= 1024 && wr_cnt <= 2048), 1);
  endtask

  task automatic run_img(input string tn, input int exp_n);
    flood();
    load_rom();
    do_reset(tn);
    wait_fin(tn);
    verify(tn, exp_n);
  endtask

  initial begin
    clr_img();
    run_img("zero", 0);

    clr_img();
    img[5][7] = 1'b1;
    run_img("dot", 1);
    chk("dot:addr167", int'(mem[167] != 8'd0), 1);

    clr_img();
    for (int i = 0; i < 32; i++) img[i][i] = 1'b1;
    run_img("diag", 1);

    clr_img();
    for (int r = 0; r < 10; r++) begin
      img[r][2] = 1'b1;
      img[r][6] = 1'b1;
    end
    for (int c = 2; c <= 6; c++) img[10][c] = 1'b1;
    run_img("ushape", 1);

    clr_img();
    for (int r = 2; r <= 5; r++) for (int c = 2; c <= 5; c++) img[r][c] = 1'b1;
    for (int r = 2; r <= 8; r++)
      for (int c = 10; c <= 16; c++)
        if (r == 2 || r == 8 || c == 10 || c == 16) img[r][c] = 1'b1;
    for (int c = 2; c <= 25; c++) img[12][c] = 1'b1;
    for (int i = 0; i <= 10; i++) img[15+i][20+i] = 1'b1;
    img[28][3] = 1'b1;
    run_img("five", 5);

    for (int t = 0; t < 4; t++) begin
      int dens;
      dens = $urandom_range(40, 5);
      for (int tries = 0; tries < 10; tries++) begin
        for (int r = 0; r < 32; r++)
          for (int c = 0; c < 32; c++) img[r][c] = ($urandom_range(99, 0) < dens);
        if (prov_cnt() <= 255) break;
        dens = 5;
      end
      run_img($sformatf("rand%0d", t), -1);
    end

    // reset in the middle of PASS1, then full re-run
    clr_img();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = ($urandom_range(99, 0) < 20);
    if (prov_cnt() > 255) clr_img();
    flood();
    load_rom();
    do_reset("midrst");
    repeat (129 + 300) @(negedge clk);
    chk("midrst:pre_finish", int'(bus.finish), 0);
    do_reset("midrst2");
    repeat (5) @(negedge clk);
    chk("midrst:rom_restart", int'(bus.rom_a), 5);
    chk("midrst:no_early_fin", int'(bus.finish), 0);
    wait_fin("midrst");
    verify("midrst", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
